// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared limits and fill-counter sizing for the programmable sequence detector.
package seq_det_pkg;

    localparam int N_MAX  = 16;
    localparam int CW_MAX = 16;

    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_sat_cnt.sv
// seq_sat_cnt: saturating up-counter with synchronous clear; a same-cycle increment wins over clear as 1.
module seq_sat_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr ? CW'(inc) : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: serial pattern detector with loadable N-bit pattern and overlap control.
// Match counter and cnt_clr exist only when SEQ_DET_CNT_EN is defined.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          seq_in,
    input  logic          seq_vld,
    input  logic [N-1:0]  pat_in,
    input  logic          pat_load,
    input  logic          overlap_en,
    input  logic          cnt_clr,
    output logic          tick,
    output logic [CW-1:0] match_cnt
);

    localparam int FW = fill_w(N);
    localparam logic [FW-1:0] FULL = FW'(N);

    if (N < 2 || N > N_MAX || CW < 1 || CW > CW_MAX) begin : g_bad_param
        $error("seq_det_prog: N or CW out of range");
    end

    logic [N-1:0]  hist_q, hist_d, pat_q, pat_d, hist_sh;
    logic [FW-1:0] fill_q, fill_d, fill_inc;
    logic          tick_q, tick_d, shift, match;

    // A load swallows any same-cycle serial bit so the new pattern starts clean.
    always_comb begin
        shift    = seq_vld && !pat_load;
        hist_sh  = {hist_q[N-2:0], seq_in};
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        match    = shift && fill_inc == FULL && hist_sh == pat_q;
        pat_d    = pat_load ? pat_in : pat_q;
        hist_d   = shift ? hist_sh : hist_q;
        fill_d   = pat_load ? '0 : !shift ? fill_q : (match && !overlap_en) ? '0 : fill_inc;
        tick_d   = match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            pat_q  <= '0;
            fill_q <= '0;
            tick_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            fill_q <= fill_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef SEQ_DET_CNT_EN
    seq_sat_cnt #(.CW(CW)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (match),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: scoreboard bench for seq_det_prog (CW=8 and CW=2 instances on shared stimulus).
module tb_seq_det_prog;

    localparam int N = 4;
`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, seq_in = 1'b0, seq_vld = 1'b0;
    logic pat_load = 1'b0, overlap_en = 1'b0, cnt_clr = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic tick, tick2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int checks = 0, errors = 0;
    bit exp_q[$];
    bit m_bits[$];
    logic [N-1:0] m_pat = '0;
    int m_cnt = 0, m_cnt2 = 0;

    always #5 clk = ~clk;

    seq_det_prog #(.N(N), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .seq_vld(seq_vld), .pat_in(pat_in),
        .pat_load(pat_load), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .tick(tick), .match_cnt(cnt)
    );

    seq_det_prog #(.N(N), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .seq_in(seq_in), .seq_vld(seq_vld), .pat_in(pat_in),
        .pat_load(pat_load), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
        .tick(tick2), .match_cnt(cnt2)
    );

    function automatic int ec();
        return CNT_EN ? m_cnt : 0;
    endfunction

    function automatic int ec2();
        return CNT_EN ? m_cnt2 : 0;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_pat  = '0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // Drives one cycle and pushes the expected tick; the result is visible #1 after the edge.
    task automatic drive(input logic vld, input logic b, input logic ld, input logic clr);
        bit hit = 1'b0;
        logic [N-1:0] v;
        @(negedge clk);
        seq_vld = vld; seq_in = b; pat_load = ld; cnt_clr = clr;
        if (ld) begin
            m_pat = pat_in;
            m_bits.delete();
        end else if (vld) begin
            m_bits.push_back(b);
            if (m_bits.size() > N) void'(m_bits.pop_front());
            v = '0;
            foreach (m_bits[i]) v = {v[N-2:0], m_bits[i]};
            hit = (m_bits.size() == N) && (v == m_pat);
            if (hit && !overlap_en) m_bits.delete();
        end
        if (clr) begin
            m_cnt  = int'(hit);
            m_cnt2 = int'(hit);
        end else if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        exp_q.push_back(hit);
        @(posedge clk);
        #1;
        seq_vld = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (tick !== 1'b0 || cnt !== 8'd0 || tick2 !== 1'b0 || cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_init: tick=%b cnt=%0d cnt2=%0d required 0/0/0", tick, cnt, cnt2);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seq_vld = 1'b1; seq_in = 1'b1; pat_load = 1'b1; pat_in = 4'b1111; cnt_clr = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (tick !== 1'b0 || cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: tick=%b cnt=%0d required 0/0", i, tick, cnt);
            end
        end
        @(negedge clk);
        seq_vld = 1'b0; pat_load = 1'b0;
        rst_n = 1'b1;
        model_reset();
        pat_in = 4'b1101;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (tick !== exp_q.pop_front() || cnt !== 8'(ec())) begin
            errors++;
            $display("FAIL reset_load: tick=%b cnt=%0d required 0/%0d", tick, cnt, ec());
        end
    endtask

    task automatic test_stream(input string name, input bit ov);
        bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
        bit e;
        overlap_en = ov;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        foreach (s[i]) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (tick !== e || tick2 !== e) begin
                errors++;
                $display("FAIL %s tick bit %0d: got %b/%b required %b", name, i + 1, tick, tick2, e);
            end
        end
        checks++;
        if (cnt !== 8'(CNT_EN ? (ov ? 2 : 1) : 0)) begin
            errors++;
            $display("FAIL %s count: got %0d required %0d", name, cnt, CNT_EN ? (ov ? 2 : 1) : 0);
        end
    endtask

    task automatic test_gap();
        bit v[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
        bit s[9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
        bit e;
        overlap_en = 1'b1;
        pat_in = 4'b1101;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        foreach (v[i]) begin
            drive(v[i], s[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (tick !== e || tick !== (i == 8)) begin
                errors++;
                $display("FAIL gap tick cyc %0d: got %b required %b", i, tick, e);
            end
        end
    endtask

    task automatic test_load();
        bit s[4] = '{0, 1, 1, 0};
        bit e;
        overlap_en = 1'b1;
        pat_in = 4'b1101;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        pat_in = 4'b0110;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) void'(exp_q.pop_front());
        foreach (s[i]) begin
            drive(1'b1, s[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (tick !== e || tick !== (i == 3)) begin
                errors++;
                $display("FAIL load tick new bit %0d: got %b required %b", i + 1, tick, e);
            end
        end
    endtask

    task automatic test_sat();
        bit e;
        overlap_en = 1'b1;
        pat_in = 4'b1111;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (tick !== e || cnt !== 8'(ec()) || cnt2 !== 2'(ec2())) begin
                errors++;
                $display("FAIL sat bit %0d: tick=%b cnt=%0d cnt2=%0d required %b/%0d/%0d",
                         i + 1, tick, cnt, cnt2, e, ec(), ec2());
            end
        end
        checks++;
        if (cnt2 !== 2'(CNT_EN ? 3 : 0) || cnt !== 8'(CNT_EN ? 8 : 0)) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d cnt2=%0d required %0d/%0d", cnt, cnt2, CNT_EN ? 8 : 0, CNT_EN ? 3 : 0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (tick !== e || cnt !== 8'(CNT_EN ? 1 : 0) || cnt2 !== 2'(CNT_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL clr_with_match: tick=%b cnt=%0d cnt2=%0d required %b/%0d", tick, cnt, cnt2, e, CNT_EN ? 1 : 0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        checks++;
        if (cnt !== 8'd0 || cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_plain: cnt=%0d cnt2=%0d required 0", cnt, cnt2);
        end
    endtask

    task automatic test_reset_mid();
        bit s[3] = '{1, 1, 0};
        bit e;
        overlap_en = 1'b1;
        pat_in = 4'b1101;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        foreach (s[i]) drive(1'b1, s[i], 1'b0, 1'b0);
        repeat (4) void'(exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0 || cnt !== 8'd0 || cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_out: tick=%b cnt=%0d required 0/0", tick, cnt);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        e = exp_q.pop_front();
        checks++;
        if (tick !== e || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tick: got %b required %b", tick, e);
        end
        foreach (s[i]) drive(1'b1, s[i], 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) void'(exp_q.pop_front());
        e = exp_q.pop_front();
        checks++;
        if (tick !== e || tick !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_recover: got %b required %b", tick, e);
        end
    endtask

    task automatic test_back_to_back();
        bit s[12] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
        bit e;
        pat_in = 4'b1101;
        overlap_en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        foreach (s[i]) begin
            overlap_en = (i >= 4);
            drive(1'b1, s[i], 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (tick !== e || cnt !== 8'(ec())) begin
                errors++;
                $display("FAIL b2b bit %0d: tick=%b cnt=%0d required %b/%0d", i + 1, tick, cnt, e, ec());
            end
        end
    endtask

    task automatic test_random();
        bit e;
        int bad = 0;
        pat_in = 4'($urandom_range(0, 15));
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) overlap_en = 1'($urandom_range(0, 1));
            pat_in = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 40) == 0));
            e = exp_q.pop_front();
            checks++;
            if (tick !== e || tick2 !== e || cnt !== 8'(ec()) || cnt2 !== 2'(ec2())) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random cyc %0d: tick=%b/%b cnt=%0d/%0d required %b cnt %0d/%0d",
                             i, tick, tick2, cnt, cnt2, e, ec(), ec2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream("overlap", 1'b1);
        test_stream("nonoverlap", 1'b0);
        test_gap();
        test_load();
        test_sat();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
